// File: rtl/fp16_exp_normalizer.sv
// Post-add normalizer: shifts the raw significand sum one bit per cycle until the hidden bit is set.
// Latency is k+2 cycles for k shifts (1 cycle for Inf/NaN bypass); the result is held until out_ready.
module fp16_exp_normalizer #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+1:0] in_mant,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [EXP_W-1:0] out_exp,
  output logic [MAN_W-1:0] out_frac,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_zero
);

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t           r_state;
  logic             r_sign;
  logic [EXP_W-1:0] r_exp;
  logic [MAN_W+1:0] r_mant;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_out_sign;
  logic [EXP_W-1:0] r_out_exp;
  logic [MAN_W-1:0] r_out_frac;
  logic             r_out_overflow;
  logic             r_out_underflow;
  logic             r_out_zero;

  logic [EXP_W-1:0] w_exp_inc;
  logic [EXP_W-1:0] w_exp_dec;

  assign w_exp_inc = r_exp + EXP_ONE;
  assign w_exp_dec = r_exp - EXP_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_sign          <= 1'b0;
      r_exp           <= '0;
      r_mant          <= '0;
      r_in_ready      <= 1'b1;
      r_out_valid     <= 1'b0;
      r_out_sign      <= 1'b0;
      r_out_exp       <= '0;
      r_out_frac      <= '0;
      r_out_overflow  <= 1'b0;
      r_out_underflow <= 1'b0;
      r_out_zero      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_in_ready <= 1'b0;
            if (in_exp == EXP_ONES) begin
              r_out_sign      <= in_sign;
              r_out_exp       <= EXP_ONES;
              r_out_frac      <= in_mant[MAN_W-1:0];
              r_out_overflow  <= 1'b0;
              r_out_underflow <= 1'b0;
              r_out_zero      <= 1'b0;
              r_out_valid     <= 1'b1;
              r_state         <= DONE;
            end else begin
              r_sign  <= in_sign;
              // Subnormal inputs carry the same weight as exponent 1.
              r_exp   <= (in_exp == '0) ? EXP_ONE : in_exp;
              r_mant  <= in_mant;
              r_state <= NORM;
            end
          end
        end
        NORM: begin
          r_out_sign      <= r_sign;
          r_out_overflow  <= 1'b0;
          r_out_underflow <= 1'b0;
          r_out_zero      <= 1'b0;
          if (r_mant == '0) begin
            r_out_exp   <= '0;
            r_out_frac  <= '0;
            r_out_zero  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_mant[MAN_W+1]) begin
            // Shifted-out LSB is dropped: no rounding at this stage.
            r_mant <= r_mant >> 1;
            r_exp  <= w_exp_inc;
            if (w_exp_inc == EXP_ONES) begin
              r_out_exp      <= EXP_ONES;
              r_out_frac     <= '0;
              r_out_overflow <= 1'b1;
              r_out_valid    <= 1'b1;
              r_state        <= DONE;
            end
          end else if (r_mant[MAN_W]) begin
            r_out_exp   <= r_exp;
            r_out_frac  <= r_mant[MAN_W-1:0];
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_exp == EXP_ONE) begin
            r_out_exp       <= '0;
            r_out_frac      <= r_mant[MAN_W-1:0];
            r_out_underflow <= 1'b1;
            r_out_valid     <= 1'b1;
            r_state         <= DONE;
          end else begin
            r_mant <= r_mant << 1;
            r_exp  <= w_exp_dec;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign out_sign      = r_out_sign;
  assign out_exp       = r_out_exp;
  assign out_frac      = r_out_frac;
  assign out_overflow  = r_out_overflow;
  assign out_underflow = r_out_underflow;
  assign out_zero      = r_out_zero;

endmodule

// File: tb/tb_fp16_exp_normalizer.sv
// Directed bench for fp16_exp_normalizer with hand-computed expected results.
module tb_fp16_exp_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [4:0]  out_exp;
  logic [9:0]  out_frac;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_zero;

  int n_checks = 0;
  int n_errors = 0;

  fp16_exp_normalizer #(.EXP_W(5), .MAN_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_exp       (in_exp),
    .in_mant      (in_mant),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sign     (out_sign),
    .out_exp      (out_exp),
    .out_frac     (out_frac),
    .out_overflow (out_overflow),
    .out_underflow(out_underflow),
    .out_zero     (out_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Issue one operand and return the cycles from the handshake to out_valid.
  task automatic issue(input logic s, input logic [4:0] e, input logic [11:0] m, output int lat);
    int wait_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 30) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_case(input string tag, input logic s, input logic [4:0] e, input logic [11:0] m,
                          input int xlat, input bit chk_lat, input logic [4:0] xe, input logic [9:0] xf,
                          input logic xov, input logic xun, input logic xz);
    int lat;
    issue(s, e, m, lat);
    if (chk_lat) chk({tag, "_lat"}, 32'(lat), 32'(xlat));
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_sign"},  32'(out_sign), 32'(s));
    chk({tag, "_exp"},   32'(out_exp), 32'(xe));
    chk({tag, "_frac"},  32'(out_frac), 32'(xf));
    chk({tag, "_ovf"},   32'(out_overflow), 32'(xov));
    chk({tag, "_unf"},   32'(out_underflow), 32'(xun));
    chk({tag, "_zero"},  32'(out_zero), 32'(xz));
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int lat;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_exp", 32'(out_exp), 32'd0);
    chk("rst_out_frac", 32'(out_frac), 32'd0);
    chk("rst_flags", 32'({out_overflow, out_underflow, out_zero, out_sign}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_case("norm",     1'b0, 5'd15, 12'h400, 2,  1'b1, 5'd15, 10'h000, 1'b0, 1'b0, 1'b0);
    run_case("carry",    1'b1, 5'd15, 12'hC00, 3,  1'b1, 5'd16, 10'h200, 1'b0, 1'b0, 1'b0);
    run_case("lshift10", 1'b0, 5'd15, 12'h001, 12, 1'b1, 5'd5,  10'h000, 1'b0, 1'b0, 1'b0);
    run_case("subnorm",  1'b1, 5'd3,  12'h040, 4,  1'b1, 5'd0,  10'h100, 1'b0, 1'b1, 1'b0);
    run_case("ovf",      1'b0, 5'd30, 12'h800, 0,  1'b0, 5'd31, 10'h000, 1'b1, 1'b0, 1'b0);
    run_case("bypass",   1'b1, 5'd31, 12'h201, 1,  1'b1, 5'd31, 10'h201, 1'b0, 1'b0, 1'b0);
    run_case("zero",     1'b0, 5'd20, 12'h000, 2,  1'b1, 5'd0,  10'h000, 1'b0, 1'b0, 1'b1);
    run_case("exp0_in",  1'b0, 5'd0,  12'h200, 2,  1'b1, 5'd0,  10'h200, 1'b0, 1'b1, 1'b0);

    // Backpressure: result must stay put while out_ready is low.
    out_ready = 1'b0;
    run_case("hold",     1'b1, 5'd15, 12'h400, 2,  1'b1, 5'd15, 10'h000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_exp", 32'(out_exp), 32'd15);
      chk("hold_frac", 32'(out_frac), 32'd0);
      chk("hold_sign", 32'(out_sign), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);

    // Reset mid-normalization drops the operand.
    in_valid = 1'b1;
    in_sign  = 1'b0;
    in_exp   = 5'd15;
    in_mant  = 12'h001;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_output", 32'(seen), 32'd0);

    run_case("post_rst", 1'b0, 5'd15, 12'hC00, 3, 1'b1, 5'd16, 10'h200, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fp16_exp_normalizer.md
Name: fp16_exp_normalizer

Overview:
- Post-add normalization stage of the half-precision adder/subtractor; the inverse end of the exponent path from the alignment subtractor.
- Alignment shifts the smaller significand right by the exponent difference. This block takes the raw significand sum and the common exponent, then shifts the significand back so the hidden bit is 1, adjusting the exponent by one per cycle.
- Iterative, one shift per cycle, with valid/ready handshakes on both sides. Handles overflow to infinity, subnormal results, zero and Inf/NaN pass-through.

Parameters:
- EXP_W, 5, exponent field width.
- MAN_W, 10, stored fraction width; the input significand is MAN_W+2 bits wide (carry, hidden, fraction).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  block can accept an operand.
- in_sign  in  1  result sign, passed through unchanged.
- in_exp  in  EXP_W  biased common exponent from alignment.
- in_mant  in  MAN_W+2  unnormalized significand sum; bit MAN_W+1 = carry, bit MAN_W = hidden.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  normalized biased exponent.
- out_frac  out  MAN_W  normalized fraction.
- out_overflow  out  1  result saturated to infinity.
- out_underflow  out  1  result is subnormal.
- out_zero  out  1  result is zero.

Behaviour:
- Reset (synchronous): state IDLE, in_ready=1, out_valid=0, all out_* fields and flags 0. Reset asserted mid-operation discards the operand in flight with no output.
- States: IDLE, NORM, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE. All outputs are registered.
- IDLE: on in_valid&in_ready, capture sign, exp and mant, then go to NORM. A captured exp of 0 is loaded as 1 (subnormal exponent weight).
- IDLE, in_exp = all ones (Inf/NaN): bypass to DONE with out_exp=all ones, out_frac=in_mant[MAN_W-1:0] and all flags 0.
- NORM, one decision per cycle, in priority order:
  1. mant==0: out_exp=0, out_frac=0, out_zero=1; go to DONE.
  2. mant[MAN_W+1]=1: mant>>=1, exp+=1. The shifted-out LSB is truncated; there is no rounding or sticky bit. If the new exp is all ones: out_exp=all ones, out_frac=0, out_overflow=1; go to DONE. Otherwise stay in NORM.
  3. mant[MAN_W]=1: already normalized. out_exp=exp, out_frac=mant[MAN_W-1:0]; go to DONE.
  4. exp==1 with hidden bit clear: subnormal. out_exp=0, out_frac=mant[MAN_W-1:0], out_underflow=1; go to DONE.
  5. Otherwise: mant<<=1, exp-=1; stay in NORM.
- Latency from the input handshake to out_valid is k+2 cycles, where k is the number of shifts. Maximum is MAN_W+2 = 12 cycles. The Inf/NaN bypass takes 1 cycle.
- DONE: all outputs are held stable while out_ready=0. On out_valid&out_ready, go to IDLE; in_ready rises the next cycle. There is no same-cycle back-to-back accept.
- At most one of out_overflow, out_underflow, out_zero is set per result.
- The exponent never wraps: it is incremented only when below all ones, and decremented only when above 1.

Test Plan:
1. in_exp=15, in_mant=0x400 -> out_valid 2 cycles after accept; exp=15, frac=0x000, all flags 0.
2. in_exp=15, in_mant=0xC00 (carry) -> latency 3; exp=16, frac=0x200.
3. in_exp=15, in_mant=0x001 -> 10 left shifts, latency 12; exp=5, frac=0x000.
4. in_exp=3, in_mant=0x040 -> 2 shifts, latency 4; exp=0, frac=0x100, underflow=1.
5. in_exp=30, in_mant=0x800 -> exp=31, frac=0, overflow=1. Separately: in_exp=31, in_mant=0x201 -> bypass with frac=0x201, latency 1. Separately: in_exp=20, in_mant=0 -> exp=0, zero=1.
6. Hold out_ready=0 for 3 cycles after case 1 -> outputs stable and in_ready=0 throughout. Then assert rst during NORM of case 3 -> next cycle in_ready=1, out_valid=0, and no result is emitted.
